// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
// Holds the FSM/owner encodings and the timeout timer sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } arb_owner_t;

    localparam int TIMEOUT_DEF = 255;
    localparam int TMR_W = $clog2(TIMEOUT_DEF + 1);

    function automatic int tmr_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Clearable up-counter; tc flags the LIMIT-th enabled cycle
// since the last clear.
module mem_arb_timer #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = en && (cnt_q == W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between fetch and data access,
// one transaction at a time, with flush, timeout and anti-starvation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_rvalid,
    output logic                if_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rvalid,
    output logic                d_err,
    output logic                stallreq_if,
    output logic                stallreq_mem,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_err
);

    localparam int BE_W = DATA_W / 8;
    localparam int TW   = tmr_width(TIMEOUT);
    localparam int SW   = $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              flushed_q, flushed_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              live_q;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

    logic tmo;
    logic if_ok, starved, pick_if, pick_mem;
    logic in_data, if_own, if_mute;
    logic rsp_ok, rsp_err, to_err;

    mem_arb_timer #(
        .W     (TW),
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state_q == ARB_IDLE),
        .en  (state_q != ARB_IDLE),
        .tc  (tmo)
    );

    assign if_ok    = if_req & ~if_flush;
    assign starved  = (starve_q == SW'(STARVE_MAX));
    assign pick_if  = if_ok & (~d_req | starved);
    assign pick_mem = d_req & ~pick_if;

    // A response in the timeout cycle takes precedence over the error.
    assign in_data = (state_q == ARB_DATA);
    assign rsp_ok  = in_data & bus_rvalid & ~bus_err;
    assign rsp_err = in_data & bus_rvalid & bus_err;
    assign to_err  = tmo & ~(in_data & bus_rvalid);
    assign if_own  = (owner_q == OWN_IF);
    assign if_mute = flushed_q | if_flush;

    assign if_rvalid = if_own & rsp_ok & ~if_mute;
    assign if_err    = if_own & (rsp_err | to_err) & ~if_mute;
    assign d_rvalid  = ~if_own & rsp_ok;
    assign d_err     = ~if_own & (rsp_err | to_err);
    assign if_rdata  = (in_data & if_own) ? bus_rdata : '0;
    assign d_rdata   = (in_data & ~if_own) ? bus_rdata : '0;

    assign stallreq_if  = live_q & if_req & ~(if_rvalid | if_err);
    assign stallreq_mem = live_q & d_req & ~(d_rvalid | d_err);

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        flushed_d   = flushed_q;
        starve_d    = starve_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                flushed_d = 1'b0;
                if (pick_if) begin
                    state_d     = ARB_ADDR;
                    owner_d     = OWN_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    starve_d    = '0;
                end else if (pick_mem) begin
                    state_d     = ARB_ADDR;
                    owner_d     = OWN_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = d_we;
                    bus_be_d    = d_be;
                    bus_addr_d  = d_addr;
                    bus_wdata_d = d_wdata;
                    if (if_req && !starved) begin
                        starve_d = starve_q + 1'b1;
                    end
                end
            end
            ARB_ADDR: begin
                if (tmo || bus_gnt) begin
                    state_d   = tmo ? ARB_IDLE : ARB_DATA;
                    bus_req_d = 1'b0;
                end
            end
            ARB_DATA: begin
                if (bus_rvalid || tmo) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (state_q != ARB_IDLE && if_own && if_flush) begin
            flushed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            flushed_q   <= 1'b0;
            starve_q    <= '0;
            live_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            flushed_q   <= flushed_d;
            starve_q    <= starve_d;
            live_q      <= 1'b1;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed corner cases
// plus random IF/MEM traffic against a random-latency bus slave.
module tb_mem_port_arbiter;

    localparam int TO = 24;

    typedef struct {
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        if_req, if_flush, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_rvalid, d_err;
    logic [3:0]  d_be, bus_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        stallreq_if, stallreq_mem;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_gnt, bus_rvalid, bus_err;
    logic [31:0] bus_rdata;

    logic        auto;
    logic        m_gnt, m_rv, m_err;
    logic [31:0] m_rdata;
    logic        a_gnt, a_rv, a_err;
    logic [31:0] a_rdata;

    assign bus_gnt    = auto ? a_gnt : m_gnt;
    assign bus_rvalid = auto ? a_rv : m_rv;
    assign bus_err    = auto ? a_err : m_err;
    assign bus_rdata  = auto ? a_rdata : m_rdata;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32),
        .TIMEOUT(TO), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_flush(if_flush), .if_rdata(if_rdata),
        .if_rvalid(if_rvalid), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .d_err(d_err),
        .stallreq_if(stallreq_if),
        .stallreq_mem(stallreq_mem),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .bus_err(bus_err)
    );

    int total = 0;
    int bad = 0;
    exp_t if_q[$];
    exp_t d_q[$];
    logic [31:0] dmodel[16];
    logic [31:0] smem[16];

    function automatic logic [31:0] ifunc(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic bit errf(input logic [31:0] a);
        return a[5:2] == 4'hD;
    endfunction

    function automatic logic [31:0] merge(
        input logic [31:0] old, input logic [31:0] wd,
        input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic chk32(input string n,
        input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b t=%0t", n, a, e, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every completion pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (if_rvalid || if_err) begin
                if (if_q.size() == 0) begin
                    chk1("if_unexpected", 1'b1, 1'b0);
                end else begin
                    e = if_q.pop_front();
                    chk1("if_err_flag", if_err, e.err);
                    if (!e.err) chk32("if_rdata", if_rdata, e.data);
                end
            end
            if (d_rvalid || d_err) begin
                if (d_q.size() == 0) begin
                    chk1("d_unexpected", 1'b1, 1'b0);
                end else begin
                    e = d_q.pop_front();
                    chk1("d_err_flag", d_err, e.err);
                    if (!e.err) chk32("d_rdata", d_rdata, e.data);
                end
            end
            chk1("stall_if", stallreq_if, if_req & ~(if_rvalid | if_err));
            chk1("stall_mem", stallreq_mem, d_req & ~(d_rvalid | d_err));
        end
    end

    // Random-latency bus slave with its own memory.
    initial begin
        bit pend;
        int wg, wr;
        logic [31:0] ca, cwd;
        logic cwe;
        logic [3:0] cbe;
        pend = 0; wg = 0; wr = 0;
        ca = '0; cwd = '0; cwe = 0; cbe = '0;
        a_gnt = 0; a_rv = 0; a_err = 0; a_rdata = '0;
        forever begin
            tick;
            a_gnt = 0; a_rv = 0; a_err = 0; a_rdata = '0;
            if (auto && !rst) begin
                if (pend) begin
                    if (wr == 0) begin
                        pend = 0;
                        a_rv = 1;
                        a_err = errf(ca);
                        if (!ca[31]) a_rdata = ifunc(ca);
                        else if (!cwe) a_rdata = smem[ca[5:2]];
                        else if (!a_err)
                            smem[ca[5:2]] = merge(smem[ca[5:2]], cwd, cbe);
                        if (a_err) a_rdata = $urandom;
                    end else begin
                        wr--;
                    end
                end else if (bus_req) begin
                    if (wg == 0) begin
                        a_gnt = 1; pend = 1;
                        ca = bus_addr; cwe = bus_we;
                        cbe = bus_be; cwd = bus_wdata;
                        wr = $urandom_range(0, 2);
                        wg = $urandom_range(0, 2);
                    end else begin
                        wg--;
                    end
                end
            end
        end
    end

    task automatic serve(input logic [31:0] rd, input logic er);
        m_gnt = 1;
        tick;
        m_gnt = 0;
        m_rv = 1; m_rdata = rd; m_err = er;
        @(negedge clk);
        tick;
        m_rv = 0; m_rdata = '0; m_err = 0;
    endtask

    task automatic push_if(input logic [31:0] v);
        exp_t e;
        e.err = 0; e.data = v;
        if_q.push_back(e);
    endtask

    task automatic push_d(input bit er, input logic [31:0] v);
        exp_t e;
        e.err = er; e.data = v;
        d_q.push_back(e);
    endtask

    task automatic flush_run(input bit late);
        if_req = 1; if_addr = 32'h400;
        tick;
        m_gnt = 1;
        tick;
        m_gnt = 0;
        if_flush = 1;
        if (late) begin
            tick;
            if_flush = 0; if_req = 0;
            tick;
        end
        m_rv = 1; m_rdata = 32'hBAD0_F00D;
        @(negedge clk);
        chk1("flush_rvalid", if_rvalid, 1'b0);
        tick;
        m_rv = 0; m_rdata = '0; if_flush = 0; if_req = 0;
        @(negedge clk);
        chk1("flush_idle", bus_req, 1'b0);
        if_req = 1; if_addr = 32'h404;
        push_if(32'h0404_0404);
        tick;
        @(negedge clk);
        chk32("flush_next_addr", bus_addr, 32'h404);
        serve(32'h0404_0404, 0);
        if_req = 0;
    endtask

    task automatic timeout_run(input bit gnt_at_to);
        d_req = 1; d_we = 0; d_be = 4'hF;
        d_addr = 32'h8000_0020;
        push_d(1, '0);
        for (int c = 1; c <= TO; c++) begin
            tick;
            if (gnt_at_to && c == TO) m_gnt = 1;
            @(negedge clk);
            if (c == TO - 1) begin
                chk1("to_early", d_err, 1'b0);
                chk1("to_breq_held", bus_req, 1'b1);
            end
            if (c == TO) chk1("to_err", d_err, 1'b1);
        end
        tick;
        m_gnt = 0; d_req = 0;
        @(negedge clk);
        chk1("to_breq_drop", bus_req, 1'b0);
        chk1("to_err_once", d_err, 1'b0);
        tick;
        m_rv = 1; m_rdata = 32'h1111_1111;
        @(negedge clk);
        chk1("late_d_rvalid", d_rvalid, 1'b0);
        chk1("late_if_rvalid", if_rvalid, 1'b0);
        tick;
        m_rv = 0; m_rdata = '0;
    endtask

    task automatic if_agent(input int n);
        logic [31:0] a;
        exp_t e;
        int t;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            a = 32'($urandom_range(0, 63)) << 2;
            if_addr = a; if_req = 1;
            e.err = errf(a); e.data = ifunc(a);
            if_q.push_back(e);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(if_rvalid || if_err) && t < 300);
            chk1("if_done", if_rvalid | if_err, 1'b1);
            tick;
            if_req = 0;
        end
    endtask

    task automatic mem_agent(input int n);
        logic [31:0] a, wd;
        logic [3:0] be;
        logic we;
        exp_t e;
        int t;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            a = 32'h8000_0000 | (32'($urandom_range(0, 15)) << 2);
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(1, 15));
            wd = $urandom;
            e.err = errf(a);
            e.data = '0;
            if (!we) e.data = dmodel[a[5:2]];
            else if (!e.err)
                dmodel[a[5:2]] = merge(dmodel[a[5:2]], wd, be);
            d_q.push_back(e);
            d_addr = a; d_we = we; d_be = be; d_wdata = wd;
            d_req = 1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!(d_rvalid || d_err) && t < 300);
            chk1("d_done", d_rvalid | d_err, 1'b1);
            tick;
            d_req = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; auto = 0;
        if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 1; d_we = 0; d_be = '0;
        d_addr = '0; d_wdata = '0;
        m_gnt = 0; m_rv = 0; m_err = 0;
        m_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 16; i++) begin
            dmodel[i] = 32'hA000_0000 + 32'(i) * 32'h0101_0101;
            smem[i] = dmodel[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_stall_mem", stallreq_mem, 1'b0);
        chk32("rst_d_rdata", d_rdata, 32'h0);
        chk32("rst_bus_addr", bus_addr, 32'h0);
        d_req = 0; m_rdata = '0;
        tick;
        rst = 0;
        @(negedge clk);
        chk1("post_rst_bus_req", bus_req, 1'b0);
        chk1("post_rst_if_rvalid", if_rvalid, 1'b0);

        // IF read alone
        tick;
        if_req = 1; if_addr = 32'h100;
        push_if(32'hDEAD_BEEF);
        @(negedge clk);
        chk1("t1_c0_breq", bus_req, 1'b0);
        chk1("t1_c0_stall", stallreq_if, 1'b1);
        tick;
        @(negedge clk);
        chk1("t1_c1_breq", bus_req, 1'b1);
        chk32("t1_c1_addr", bus_addr, 32'h100);
        tick;
        m_gnt = 1;
        @(negedge clk);
        chk1("t1_c2_breq", bus_req, 1'b1);
        tick;
        m_gnt = 0; m_rv = 1; m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("t1_c3_rvalid", if_rvalid, 1'b1);
        chk1("t1_c3_stall", stallreq_if, 1'b0);
        chk1("t1_c3_breq", bus_req, 1'b0);
        tick;
        m_rv = 0; m_rdata = '0; if_req = 0;

        // IF and MEM together: MEM first
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 1; d_be = 4'hF;
        d_addr = 32'h8000_0010; d_wdata = 32'h5555_AAAA;
        push_d(0, '0);
        push_if(32'h0000_2222);
        tick;
        @(negedge clk);
        chk1("t2_we", bus_we, 1'b1);
        chk32("t2_addr", bus_addr, 32'h8000_0010);
        chk32("t2_wdata", bus_wdata, 32'h5555_AAAA);
        serve('0, 0);
        d_req = 0;
        tick;
        @(negedge clk);
        chk32("t2_if_addr", bus_addr, 32'h200);
        chk1("t2_if_we", bus_we, 1'b0);
        serve(32'h0000_2222, 0);
        if_req = 0;

        // Starvation: 4 MEM grants, then IF
        if_req = 1; if_addr = 32'h300;
        d_req = 1; d_we = 0; d_addr = 32'h8000_0004;
        push_if(32'h0300_0300);
        for (int i = 0; i < 5; i++) push_d(0, 32'hC0DE_0000 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            tick;
            @(negedge clk);
            chk32("t3_mem_grant", bus_addr, 32'h8000_0004);
            serve(32'hC0DE_0000 + 32'(i), 0);
        end
        tick;
        @(negedge clk);
        chk32("t3_if_forced", bus_addr, 32'h300);
        serve(32'h0300_0300, 0);
        if_req = 0;
        tick;
        @(negedge clk);
        chk32("t3_mem_after", bus_addr, 32'h8000_0004);
        serve(32'hC0DE_0004, 0);
        d_req = 0;

        flush_run(1);
        flush_run(0);
        timeout_run(0);
        timeout_run(1);

        // Reset while in DATA
        d_req = 1; d_we = 1; d_be = 4'h3;
        d_addr = 32'h8000_0008; d_wdata = 32'h1234_0000;
        tick;
        m_gnt = 1;
        tick;
        m_gnt = 0;
        #2;
        rst = 1; m_rv = 1; m_rdata = 32'h7777_7777;
        #1;
        chk1("t6_breq", bus_req, 1'b0);
        chk1("t6_stall", stallreq_mem, 1'b0);
        chk1("t6_drvalid", d_rvalid, 1'b0);
        chk32("t6_drdata", d_rdata, 32'h0);
        d_req = 0;
        tick;
        m_rv = 0; m_rdata = '0;
        tick;
        rst = 0;
        @(negedge clk);
        chk1("t6_post_breq", bus_req, 1'b0);
        tick;
        d_req = 1;
        push_d(0, '0);
        tick;
        @(negedge clk);
        chk1("t6_new_breq", bus_req, 1'b1);
        chk1("t6_new_we", bus_we, 1'b1);
        serve('0, 0);
        d_req = 0;

        // Random traffic against the auto slave
        auto = 1;
        fork
            if_agent(40);
            mem_agent(60);
        join
        repeat (4) @(posedge clk);
        auto = 0;
        @(negedge clk);
        chk32("if_q_left", 32'(if_q.size()), 32'h0);
        chk32("d_q_left", 32'(d_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
